// File: rtl/eprisc_gpio_port_if.sv
// Request side of the epRISC I/O controller internal bus as seen by a decoded peripheral.
interface eprisc_gpio_port_if;
    logic [14:0] iAddr;
    logic [15:0] iData;
    logic        iWrite;
    logic        iEnable;

    modport master (output iAddr, output iData, output iWrite, output iEnable);
    modport slave  (input  iAddr, input  iData, input  iWrite, input  iEnable);
endinterface

// File: rtl/eprisc_gpio_port.sv
// 16-pin GPIO block: direction, output latch with set/clear/toggle, synchronized readback.
// Edge interrupts (RISE_EN/FALL_EN/STATUS, oInt) exist only when GPIO_IRQ_EN is defined.
module eprisc_gpio_port #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    output logic                oInt,
    eprisc_gpio_port_if.slave   bus,
    output wire  [31:0]         oData,
    inout  wire                 bGPIO0,
    inout  wire                 bGPIO1,
    inout  wire                 bGPIO2,
    inout  wire                 bGPIO3,
    inout  wire                 bGPIO4,
    inout  wire                 bGPIO5,
    inout  wire                 bGPIO6,
    inout  wire                 bGPIO7,
    inout  wire                 bGPIO8,
    inout  wire                 bGPIO9,
    inout  wire                 bGPIO10,
    inout  wire                 bGPIO11,
    inout  wire                 bGPIO12,
    inout  wire                 bGPIO13,
    inout  wire                 bGPIO14,
    inout  wire                 bGPIO15
);
    localparam int unsigned PIN_W  = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] ADDR_IN     = 4'h0;
    localparam logic [3:0] ADDR_DIR    = 4'h1;
    localparam logic [3:0] ADDR_OUT    = 4'h2;
    localparam logic [3:0] ADDR_SET    = 4'h3;
    localparam logic [3:0] ADDR_CLR    = 4'h4;
    localparam logic [3:0] ADDR_TGL    = 4'h5;
`ifdef GPIO_IRQ_EN
    localparam logic [3:0] ADDR_RISE   = 4'h6;
    localparam logic [3:0] ADDR_FALL   = 4'h7;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
`endif

    logic              wInternalReset;
    logic [3:0]        regAddr;
    logic              wrEn;
    logic              rdEn;
    logic              unusedAddrHigh;
    logic [PIN_W-1:0]  pinLevel;
    logic [PIN_W-1:0]  regDir;
    logic [PIN_W-1:0]  regOut;
    logic [PIN_W-1:0]  outNext;
    logic [PIN_W-1:0]  regIn;
    logic [PIN_W-1:0]  syncPipe [SYNC_STAGES];
    logic [PIN_W-1:0]  rdReg;

    assign wInternalReset = iRst;
    assign regAddr        = bus.iAddr[3:0];
    assign wrEn           = bus.iEnable & bus.iWrite;
    assign rdEn           = bus.iEnable & ~bus.iWrite;
    assign unusedAddrHigh = ^bus.iAddr[14:4];

    assign pinLevel = {bGPIO15, bGPIO14, bGPIO13, bGPIO12, bGPIO11, bGPIO10, bGPIO9, bGPIO8,
                       bGPIO7,  bGPIO6,  bGPIO5,  bGPIO4,  bGPIO3,  bGPIO2,  bGPIO1, bGPIO0};

    assign bGPIO0  = regDir[0]  ? regOut[0]  : 1'bz;
    assign bGPIO1  = regDir[1]  ? regOut[1]  : 1'bz;
    assign bGPIO2  = regDir[2]  ? regOut[2]  : 1'bz;
    assign bGPIO3  = regDir[3]  ? regOut[3]  : 1'bz;
    assign bGPIO4  = regDir[4]  ? regOut[4]  : 1'bz;
    assign bGPIO5  = regDir[5]  ? regOut[5]  : 1'bz;
    assign bGPIO6  = regDir[6]  ? regOut[6]  : 1'bz;
    assign bGPIO7  = regDir[7]  ? regOut[7]  : 1'bz;
    assign bGPIO8  = regDir[8]  ? regOut[8]  : 1'bz;
    assign bGPIO9  = regDir[9]  ? regOut[9]  : 1'bz;
    assign bGPIO10 = regDir[10] ? regOut[10] : 1'bz;
    assign bGPIO11 = regDir[11] ? regOut[11] : 1'bz;
    assign bGPIO12 = regDir[12] ? regOut[12] : 1'bz;
    assign bGPIO13 = regDir[13] ? regOut[13] : 1'bz;
    assign bGPIO14 = regDir[14] ? regOut[14] : 1'bz;
    assign bGPIO15 = regDir[15] ? regOut[15] : 1'bz;

    // Output latch update: direct write or bitwise set/clear/toggle strobes.
    always_comb begin
        outNext = regOut;
        if (wrEn) begin
            case (regAddr)
                ADDR_OUT: outNext = bus.iData;
                ADDR_SET: outNext = regOut | bus.iData;
                ADDR_CLR: outNext = regOut & ~bus.iData;
                ADDR_TGL: outNext = regOut ^ bus.iData;
                default:  outNext = regOut;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (wInternalReset) begin
            regDir <= '0;
            regOut <= '0;
        end else begin
            if (wrEn && (regAddr == ADDR_DIR)) regDir <= bus.iData;
            regOut <= outNext;
        end
    end

    // Pin synchronizer; IN samples the pad itself so driven outputs read back too.
    always_ff @(posedge iClk) begin
        if (wInternalReset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) syncPipe[i] <= '0;
        end else begin
            syncPipe[0] <= pinLevel;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) syncPipe[i] <= syncPipe[i-1];
        end
    end

    assign regIn = syncPipe[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
    logic [PIN_W-1:0] regRiseEn;
    logic [PIN_W-1:0] regFallEn;
    logic [PIN_W-1:0] regStatus;
    logic [PIN_W-1:0] regPrev;
    logic [PIN_W-1:0] statusClr;
    logic [PIN_W-1:0] statusNext;

    // New edge events are OR-ed in after the W1C mask so a coincident edge survives the clear.
    always_comb begin
        statusClr  = '0;
        if (wrEn && (regAddr == ADDR_STATUS)) statusClr = bus.iData;
        statusNext = (regStatus & ~statusClr)
                   | (regIn & ~regPrev & regRiseEn)
                   | (~regIn & regPrev & regFallEn);
    end

    always_ff @(posedge iClk) begin
        if (wInternalReset) begin
            regRiseEn <= '0;
            regFallEn <= '0;
            regStatus <= '0;
            regPrev   <= '0;
        end else begin
            if (wrEn && (regAddr == ADDR_RISE)) regRiseEn <= bus.iData;
            if (wrEn && (regAddr == ADDR_FALL)) regFallEn <= bus.iData;
            regStatus <= statusNext;
            regPrev   <= regIn;
        end
    end

    assign oInt = |regStatus;
`else
    assign oInt = 1'b0;
`endif

    always_comb begin
        rdReg = '0;
        case (regAddr)
            ADDR_IN:     rdReg = regIn;
            ADDR_DIR:    rdReg = regDir;
            ADDR_OUT:    rdReg = regOut;
`ifdef GPIO_IRQ_EN
            ADDR_RISE:   rdReg = regRiseEn;
            ADDR_FALL:   rdReg = regFallEn;
            ADDR_STATUS: rdReg = regStatus;
`endif
            default:     rdReg = '0;
        endcase
    end

    // Shared read bus: release it whenever this block is not being read.
    assign oData = rdEn ? {16'h0000, rdReg} : {DATA_W{1'bz}};
endmodule

// File: tb/tb_eprisc_gpio_port.sv
// Directed bench for eprisc_gpio_port; interrupt expectations follow GPIO_IRQ_EN.
module tb_eprisc_gpio_port;
    localparam int unsigned SYNC = 2;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    logic iClk;
    logic iRst;
    logic oInt;
    logic drv8En, drv8Val, drv15En, drv15Val;
    tri1  [31:0] rdData;
    tri1  pin0, pin1, pin2, pin3, pin4, pin5, pin6, pin7;
    tri1  pin8, pin9, pin10, pin11, pin12, pin13, pin14, pin15;
    wire  [15:0] pinsV;

    int   nAsserts = 0;
    int   nFails   = 0;
    sb_t  sbQ[$];

    eprisc_gpio_port_if busIf();

    eprisc_gpio_port #(.SYNC_STAGES(SYNC)) dut (
        .iClk(iClk), .iRst(iRst), .oInt(oInt), .bus(busIf), .oData(rdData),
        .bGPIO0(pin0),   .bGPIO1(pin1),   .bGPIO2(pin2),   .bGPIO3(pin3),
        .bGPIO4(pin4),   .bGPIO5(pin5),   .bGPIO6(pin6),   .bGPIO7(pin7),
        .bGPIO8(pin8),   .bGPIO9(pin9),   .bGPIO10(pin10), .bGPIO11(pin11),
        .bGPIO12(pin12), .bGPIO13(pin13), .bGPIO14(pin14), .bGPIO15(pin15)
    );

    // Undriven pins and an idle read bus float high through the tri1 pull.
    assign pin8  = drv8En  ? drv8Val  : 1'bz;
    assign pin15 = drv15En ? drv15Val : 1'bz;
    assign pinsV = {pin15, pin14, pin13, pin12, pin11, pin10, pin9, pin8,
                    pin7,  pin6,  pin5,  pin4,  pin3,  pin2,  pin1, pin0};

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [31:0] irqv(input logic [31:0] v);
        return IRQ ? v : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [15:0] d);
        @(negedge iClk);
        busIf.iAddr = 15'(a); busIf.iData = d; busIf.iWrite = 1'b1; busIf.iEnable = 1'b1;
        @(negedge iClk);
        busIf.iWrite = 1'b0; busIf.iEnable = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] a, input string tag, input logic [31:0] e);
        sb_t s;
        @(negedge iClk);
        busIf.iAddr = 15'(a); busIf.iWrite = 1'b0; busIf.iEnable = 1'b1;
        sbQ.push_back('{tag, e});
        #1;
        s = sbQ.pop_front();
        check(s.tag, rdData, s.exp);
        busIf.iEnable = 1'b0;
    endtask

    task automatic waitClk(input int unsigned n);
        repeat (n) @(negedge iClk);
    endtask

    initial begin
        iRst = 1'b1;
        busIf.iAddr = '0; busIf.iData = '0; busIf.iWrite = 1'b0; busIf.iEnable = 1'b0;
        drv8En = 1'b0; drv8Val = 1'b0; drv15En = 1'b0; drv15Val = 1'b0;
        waitClk(2);
        #1;
        check("reset_oint", {31'h0, oInt}, 32'h0);
        check("reset_pins_hiz", {16'h0, pinsV}, 32'h0000FFFF);
        iRst = 1'b0;
        busRead(4'h1, "reset_dir", 32'h0);
        busRead(4'h2, "reset_out", 32'h0);
        busRead(4'h8, "reset_status", 32'h0);
        waitClk(SYNC);
        busRead(4'h0, "reset_in_floating", 32'h0000FFFF);

        // Low byte driven, high byte floating.
        busWrite(4'h1, 16'h00FF);
        busWrite(4'h2, 16'hA5A5);
        #1;
        check("pins_low_byte_drive", {16'h0, pinsV}, 32'h0000FFA5);
        busRead(4'h2, "out_a5a5", 32'h0000A5A5);
        waitClk(SYNC);
        busRead(4'h0, "in_after_sync", 32'h0000FFA5);

        busWrite(4'h3, 16'h0F00);
        busWrite(4'h4, 16'h0005);
        busRead(4'h2, "out_set_clr", 32'h0000AFA0);
        busWrite(4'h5, 16'hFFFF);
        busRead(4'h2, "out_tgl", 32'h0000505F);
        busRead(4'h3, "set_reads_zero", 32'h0);
        busRead(4'h9, "addr9_reads_zero", 32'h0);
        busWrite(4'h0, 16'h1234);
        busRead(4'h1, "in_write_ignored_dir", 32'h000000FF);
        busRead(4'h2, "in_write_ignored_out", 32'h0000505F);
        waitClk(SYNC);
        busRead(4'h0, "in_after_tgl", 32'h0000FF5F);

        // Rising edge on pin 8.
        busWrite(4'h6, 16'h0100);
        busRead(4'h6, "rise_en_rb", irqv(32'h0100));
        @(negedge iClk); drv8En = 1'b1; drv8Val = 1'b0;
        waitClk(SYNC + 2);
        busRead(4'h8, "fall_not_enabled", 32'h0);
        @(negedge iClk); drv8Val = 1'b1;
        waitClk(SYNC - 1);
        busRead(4'h8, "status_before_rise", 32'h0);
        check("oint_before_rise", {31'h0, oInt}, 32'h0);
        busRead(4'h8, "status_rise", irqv(32'h0100));
        check("oint_rise", {31'h0, oInt}, irqv(32'h1));
        busWrite(4'h8, 16'h0100);
        busRead(4'h8, "status_w1c", 32'h0);
        check("oint_w1c", {31'h0, oInt}, 32'h0);
        @(negedge iClk); drv8Val = 1'b0;
        waitClk(SYNC + 2);
        busRead(4'h8, "no_fall_event", 32'h0);

        // Falling edge on pin 15 coincident with a W1C of the same bit.
        busWrite(4'h7, 16'h8000);
        @(negedge iClk); drv15En = 1'b1; drv15Val = 1'b1;
        waitClk(SYNC + 2);
        busRead(4'h8, "status_before_fall", 32'h0);
        @(negedge iClk); drv15Val = 1'b0;
        waitClk(SYNC);
        busIf.iAddr = 15'h8; busIf.iData = 16'h8000; busIf.iWrite = 1'b1; busIf.iEnable = 1'b1;
        @(negedge iClk);
        busIf.iWrite = 1'b0; busIf.iEnable = 1'b0;
        busRead(4'h8, "set_wins_over_clear", irqv(32'h8000));
        check("oint_fall", {31'h0, oInt}, irqv(32'h1));
        busWrite(4'h8, 16'h8000);
        busRead(4'h8, "status_fall_cleared", 32'h0);

        // Disabling the enable keeps a latched event.
        @(negedge iClk); drv8Val = 1'b1;
        waitClk(SYNC + 2);
        busWrite(4'h6, 16'h0000);
        busRead(4'h8, "status_kept_after_disable", irqv(32'h0100));
        busRead(4'h6, "rise_en_cleared", 32'h0);

        // Bus release and unselected writes.
        @(negedge iClk);
        busIf.iAddr = 15'h2; busIf.iWrite = 1'b0; busIf.iEnable = 1'b0;
        #1;
        check("odata_hiz_not_enabled", rdData, 32'hFFFFFFFF);
        busIf.iAddr = 15'h9; busIf.iData = 16'hFFFF; busIf.iWrite = 1'b1; busIf.iEnable = 1'b1;
        #1;
        check("odata_hiz_on_write", rdData, 32'hFFFFFFFF);
        @(negedge iClk);
        busIf.iAddr = 15'h1; busIf.iEnable = 1'b0;
        @(negedge iClk);
        busIf.iWrite = 1'b0;
        busRead(4'h1, "write_without_enable", 32'h000000FF);
        busRead(4'h9, "addr9_write_ignored", 32'h0);

        // Reset mid-operation with a concurrent write.
        @(negedge iClk);
        drv8En = 1'b0; drv15En = 1'b0;
        iRst = 1'b1;
        busIf.iAddr = 15'h1; busIf.iData = 16'hFFFF; busIf.iWrite = 1'b1; busIf.iEnable = 1'b1;
        @(negedge iClk);
        iRst = 1'b0; busIf.iWrite = 1'b0; busIf.iEnable = 1'b0;
        #1;
        check("midrst_oint", {31'h0, oInt}, 32'h0);
        check("midrst_pins_hiz", {16'h0, pinsV}, 32'h0000FFFF);
        busRead(4'h1, "midrst_dir", 32'h0);
        busRead(4'h2, "midrst_out", 32'h0);
        busRead(4'h8, "midrst_status", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
